// File: rtl/serial_pattern_gen_pkg.sv
// Shared constants for the serial pattern generator and checker.
// Stream width defaults and generator FSM encodings.
package serial_pattern_gen_pkg;

    localparam int SPG_WIDTH = 8;
    localparam int SPG_CNT_W = 4;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_SHIFT  = 2'b01;
    localparam logic [1:0] ST_FINISH = 2'b10;

endpackage

// File: rtl/serial_pattern_gen.sv
// Serializes a captured pattern word MSB-first, repeated
// repeat_n+1 times back-to-back, with abort and busy/done status.
module serial_pattern_gen
    import serial_pattern_gen_pkg::*;
#(
    parameter int WIDTH = SPG_WIDTH,
    parameter int CNT_W = SPG_CNT_W
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_n,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] copy_q, copy_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] pass_q, pass_d;
    logic             x_q, x_d;
    logic             xv_q, xv_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Next-state and next-output decode; outputs default low so that
    // abort, FINISH exit and the unused encoding all land quietly in IDLE.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        copy_d  = copy_q;
        idx_d   = idx_q;
        pass_d  = pass_q;
        x_d     = 1'b0;
        xv_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d = ST_SHIFT;
                    shreg_d = pattern;
                    copy_d  = pattern;
                    pass_d  = repeat_n;
                    idx_d   = IDX_TOP;
                    x_d     = pattern[WIDTH-1];
                    xv_d    = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (idx_q != '0) begin
                    shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                    x_d     = shreg_q[WIDTH-2];
                    idx_d   = idx_q - IDX_W'(1);
                    xv_d    = 1'b1;
                    busy_d  = 1'b1;
                end else if (pass_q != '0) begin
                    pass_d  = pass_q - CNT_W'(1);
                    shreg_d = copy_q;
                    x_d     = copy_q[WIDTH-1];
                    idx_d   = IDX_TOP;
                    xv_d    = 1'b1;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_FINISH;
                    done_d  = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            copy_q  <= '0;
            idx_q   <= '0;
            pass_q  <= '0;
            x_q     <= 1'b0;
            xv_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            copy_q  <= copy_d;
            idx_q   <= idx_d;
            pass_q  <= pass_d;
            x_q     <= x_d;
            xv_q    <= xv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign x       = x_q;
    assign x_valid = xv_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Self-checking bench for serial_pattern_gen.
// Expected streams are built as bit queues from pattern and pass count.
module tb_serial_pattern_gen;

    localparam int W = 8;
    localparam int C = 4;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic [W-1:0] pattern = '0;
    logic [C-1:0] repeat_n = '0;
    logic         x, x_valid, busy, done;

    int n_pass = 0;
    int n_total = 0;

    serial_pattern_gen #(.WIDTH(W), .CNT_W(C)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .stop(stop),
        .pattern(pattern), .repeat_n(repeat_n),
        .x(x), .x_valid(x_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".x"}, 32'(x), 32'd0);
        chk({tag, ".x_valid"}, 32'(x_valid), 32'd0);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".done"}, 32'(done), 32'd0);
    endtask

    // Full run: expected stream is the word MSB-first, repeated rep+1 times.
    // With perturb set, inputs are scrambled after capture.
    task automatic run(input string tag, input logic [W-1:0] pat,
                       input int rep, input bit perturb);
        bit q[$];
        q = {};
        for (int p = 0; p <= rep; p++)
            for (int b = W - 1; b >= 0; b--)
                q.push_back(pat[b]);
        start = 1'b1;
        pattern = pat;
        repeat_n = C'(rep);
        step();
        start = 1'b0;
        for (int i = 0; i < q.size(); i++) begin
            chk($sformatf("%s.bit%0d", tag, i), 32'(x), 32'(q[i]));
            chk($sformatf("%s.v%0d", tag, i), 32'(x_valid), 32'd1);
            chk($sformatf("%s.busy%0d", tag, i), 32'(busy), 32'd1);
            chk($sformatf("%s.nodone%0d", tag, i), 32'(done), 32'd0);
            if (perturb) begin
                start = 1'($urandom_range(0, 1));
                pattern = '0;
                repeat_n = C'($urandom);
            end
            step();
        end
        start = 1'b0;
        chk({tag, ".done"}, 32'(done), 32'd1);
        chk({tag, ".fin_busy"}, 32'(busy), 32'd1);
        chk({tag, ".fin_v"}, 32'(x_valid), 32'd0);
        chk({tag, ".fin_x"}, 32'(x), 32'd0);
        step();
        chk_quiet({tag, ".idle"});
    endtask

    initial begin
        #3;
        chk_quiet("reset");
        step();
        chk_quiet("reset_edge");
        n_rst = 1'b1;
        step();
        chk_quiet("post_reset");

        run("basic", 8'b1011_0010, 0, 1'b0);
        run("repeat", 8'hA5, 2, 1'b0);

        // Abort on the third bit cycle.
        start = 1'b1;
        pattern = 8'hFF;
        repeat_n = '0;
        step();
        start = 1'b0;
        step();
        step();
        chk("abort.bit3", 32'(x), 32'd1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        for (int i = 0; i < 10; i++)
            chk_quiet($sformatf("abort.after%0d", i));
        for (int i = 0; i < 10; i++)
            step();
        run("fresh", 8'h96, 0, 1'b0);

        // Capture isolation, then no phantom second run.
        run("isolate", 8'hC3, 0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk_quiet($sformatf("noresume%0d", i));
        end

        // Async reset mid-run after four bits.
        start = 1'b1;
        pattern = 8'h5A;
        repeat_n = 4'd1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        chk("rst.bit3", 32'(x), 32'd1);
        chk("rst.busy", 32'(busy), 32'd1);
        #2;
        n_rst = 1'b0;
        #1;
        chk_quiet("rst.async");
        #3;
        n_rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_quiet($sformatf("rst.idle%0d", i));
        end

        // start with stop in IDLE is ignored.
        start = 1'b1;
        stop = 1'b1;
        pattern = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_quiet($sformatf("startstop%0d", i));
        end
        start = 1'b0;
        stop = 1'b0;

        // Back-to-back: restart on the first IDLE edge after done.
        run("b2b_a", 8'h3C, 1, 1'b0);
        run("b2b_b", 8'hE1, 0, 1'b0);

        // Randomized runs against the queue model.
        for (int r = 0; r < 6; r++)
            run($sformatf("rnd%0d", r), W'($urandom),
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
